// File: rtl/health_pkg.sv
// health_pkg: detector sample widths, scheduler FSM states and a saturating increment helper.
package health_pkg;
    localparam int PH_W = 4;
    localparam int TYPE_W = 3;

    typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE} state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        return (v == max) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after last_grant, wrapping.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    input  logic          any,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);
    logic [IW-1:0] idx;

    // Scan from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        grant_idx = '0;
        grant_valid = 1'b0;
        idx = '0;
        for (int k = N; k >= 1; k--) begin
            idx = IW'((int'(last_grant) + k) % N);
            if (any && req[idx]) begin
                grant_idx = idx;
                grant_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/blood_check_scheduler.sv
// blood_check_scheduler: round-robin time-sharing of one blood abnormality detector across patients.
// Define ALARM_DEBOUNCE_EN to raise an alarm only on two consecutive abnormal verdicts per patient.
module blood_check_scheduler
    import health_pkg::*;
#(
    parameter int NUM_PATIENTS = 4,
    parameter int CNT_W = 8,
    localparam int IW = $clog2(NUM_PATIENTS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_PATIENTS-1:0]      req,
    input  logic [PH_W*NUM_PATIENTS-1:0] ph_in,
    input  logic [TYPE_W*NUM_PATIENTS-1:0] type_in,
    output logic [NUM_PATIENTS-1:0]      ack,
    output logic [PH_W-1:0]              det_ph,
    output logic [TYPE_W-1:0]            det_type,
    input  logic                         det_abnormal,
    output logic                         result_valid,
    output logic [IW-1:0]                result_id,
    output logic                         result_abn,
    output logic [NUM_PATIENTS-1:0]      alarm,
    input  logic [NUM_PATIENTS-1:0]      alarm_clr,
    output logic [CNT_W-1:0]             abn_count,
    output logic                         busy
);
    state_t state, nxt;
    logic [IW-1:0] grant, last_grant, arb_idx;
    logic arb_valid;
    logic [NUM_PATIENTS-1:0] set_vec;

    rr_arbiter #(.N(NUM_PATIENTS)) u_arb (
        .req(req),
        .last_grant(last_grant),
        .any(state == IDLE),
        .grant_idx(arb_idx),
        .grant_valid(arb_valid)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        nxt = (state == IDLE) ? (arb_valid ? DRIVE : IDLE) : (state == DRIVE) ? CAPTURE : IDLE;
    end

`ifdef ALARM_DEBOUNCE_EN
    logic [NUM_PATIENTS-1:0] streak;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) streak <= '0;
        else if (state == CAPTURE) streak[grant] <= det_abnormal;

    assign set_vec = (state == CAPTURE && det_abnormal && streak[grant]) ?
                     NUM_PATIENTS'(1) << grant : '0;
`else
    assign set_vec = (state == CAPTURE && det_abnormal) ? NUM_PATIENTS'(1) << grant : '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack <= '0;
            det_ph <= '0;
            det_type <= '0;
            result_valid <= 1'b0;
            result_id <= '0;
            result_abn <= 1'b0;
            alarm <= '0;
            abn_count <= '0;
            grant <= '0;
            last_grant <= IW'(NUM_PATIENTS - 1);
        end else begin
            ack <= '0;
            result_valid <= 1'b0;
            alarm <= (alarm & ~alarm_clr) | set_vec;
            if (state == IDLE && arb_valid) begin
                det_ph <= ph_in[arb_idx*PH_W +: PH_W];
                det_type <= type_in[arb_idx*TYPE_W +: TYPE_W];
                grant <= arb_idx;
            end
            if (state == CAPTURE) begin
                ack[grant] <= 1'b1;
                result_valid <= 1'b1;
                result_id <= grant;
                result_abn <= det_abnormal;
                last_grant <= grant;
                if (det_abnormal)
                    abn_count <= CNT_W'(sat_inc(32'(abn_count), 32'({CNT_W{1'b1}})));
            end
        end
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_blood_check_scheduler.sv
// tb_blood_check_scheduler: directed stimulus with a result scoreboard for blood_check_scheduler.
module tb_blood_check_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [15:0] ph_in = '0;
    logic [11:0] type_in = '0;
    logic [3:0] ack;
    logic [3:0] det_ph;
    logic [2:0] det_type;
    logic det_abnormal;
    logic result_valid;
    logic [1:0] result_id;
    logic result_abn;
    logic [3:0] alarm;
    logic [3:0] alarm_clr = '0;
    logic [7:0] abn_count;
    logic busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] id;
        logic       abn;
        logic [7:0] cnt;
        logic [3:0] alm;
    } exp_t;

    exp_t sb[$];
    logic [7:0] mcnt = '0;
    logic [3:0] malarm = '0;
    logic [3:0] mstreak = '0;

    blood_check_scheduler #(.NUM_PATIENTS(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ph_in(ph_in), .type_in(type_in),
        .ack(ack), .det_ph(det_ph), .det_type(det_type), .det_abnormal(det_abnormal),
        .result_valid(result_valid), .result_id(result_id), .result_abn(result_abn),
        .alarm(alarm), .alarm_clr(alarm_clr), .abn_count(abn_count), .busy(busy)
    );

    // Detector stub: only pH code 7 counts as a normal sample.
    assign det_abnormal = (det_ph != 4'd7);

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void expect_result(int id, logic abn, logic [3:0] clr);
        exp_t e;
        logic [3:0] set;
        set = '0;
        if (abn) begin
            mcnt = (mcnt == 8'hFF) ? mcnt : mcnt + 8'd1;
`ifdef ALARM_DEBOUNCE_EN
            if (mstreak[id]) set[id] = 1'b1;
`else
            set[id] = 1'b1;
`endif
        end
        mstreak[id] = abn;
        malarm = (malarm & ~clr) | set;
        e.id = 2'(id);
        e.abn = abn;
        e.cnt = mcnt;
        e.alm = malarm;
        sb.push_back(e);
    endfunction

    task automatic reset_dut();
        rst_n = 1'b0;
        req = '0;
        alarm_clr = '0;
        repeat (2) @(negedge clk);
        sb.delete();
        mcnt = '0;
        malarm = '0;
        mstreak = '0;
        rst_n = 1'b1;
    endtask

    task automatic wait_ack();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(|ack) && n < 12);
        chk("ack_timeout", 32'(|ack), 32'd1);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && result_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 32'(result_id), 32'hFFFF);
                end else begin
                    e = sb.pop_front();
                    chk("result_id", 32'(result_id), 32'(e.id));
                    chk("result_abn", 32'(result_abn), 32'(e.abn));
                    chk("ack_onehot", 32'(ack), 32'(4'b0001 << e.id));
                    chk("abn_count", 32'(abn_count), 32'(e.cnt));
                    chk("alarm", 32'(alarm), 32'(e.alm));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_dut();
        repeat (20) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 32'd0);
        end
        chk("reset_outputs", 32'({ack, det_ph, det_type, result_valid, result_id,
                                  result_abn, alarm, abn_count, busy}), 32'd0);

        // Single normal check for patient 1, with exact latency.
        ph_in[7:4] = 4'd7;
        type_in[5:3] = 3'd1;
        req = 4'b0010;
        expect_result(1, 1'b0, 4'b0000);
        @(posedge clk); #1;
        chk("single_det_ph", 32'(det_ph), 32'd7);
        chk("single_det_type", 32'(det_type), 32'd1);
        chk("single_busy", 32'(busy), 32'd1);
        ph_in[7:4] = 4'd2;
        @(posedge clk); #1;
        chk("single_no_early_valid", 32'(result_valid), 32'd0);
        @(posedge clk); #1;
        chk("single_ack", 32'(ack), 32'b0010);
        req = '0;
        @(negedge clk);
        chk("single_alarm", 32'(alarm), 32'd0);

        // Round-robin with every patient requesting abnormal samples.
        reset_dut();
        ph_in = 16'h3333;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) expect_result(k % 4, 1'b1, 4'b0000);
        repeat (5) wait_ack();
        req = '0;
        repeat (3) @(negedge clk);
        chk("rr_count", 32'(abn_count), 32'd5);
        chk("rr_alarm", 32'(alarm), 32'(malarm));

        // Clear for patient 2 collides with its abnormal capture: set wins.
        ph_in[11:8] = 4'd0;
        req = 4'b0100;
        expect_result(2, 1'b1, 4'b0100);
        @(negedge clk);
        @(negedge clk);
        alarm_clr = 4'b0100;
        @(negedge clk);
        alarm_clr = '0;
        req = '0;
        chk("race_ack", 32'(ack), 32'b0100);
        chk("race_alarm", 32'(alarm), 32'(malarm));
        alarm_clr = 4'b0100;
        @(negedge clk);
        alarm_clr = '0;
        malarm = malarm & ~4'b0100;
        chk("clear_alarm", 32'(alarm), 32'(malarm));

        // Patient 0 verdict sequence: abnormal, normal, abnormal, abnormal.
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            ph_in[3:0] = (k == 1) ? 4'd7 : 4'd0;
            req = 4'b0001;
            expect_result(0, k != 1, 4'b0000);
            wait_ack();
            req = '0;
            chk("seq_alarm", 32'(alarm), 32'(malarm));
        end

        // Counter saturation with patient 3 held requesting.
        reset_dut();
        ph_in[15:12] = 4'd0;
        req = 4'b1000;
        for (int k = 0; k < 256; k++) expect_result(3, 1'b1, 4'b0000);
        repeat (256) wait_ack();
        req = '0;
        @(negedge clk);
        chk("sat_count", 32'(abn_count), 32'd255);

        // Asynchronous reset during DRIVE aborts the check.
        ph_in[7:4] = 4'd0;
        req = 4'b0010;
        @(posedge clk); #1;
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        req = '0;
        sb.delete();
        mcnt = '0;
        malarm = '0;
        mstreak = '0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_count", 32'(abn_count), 32'd0);
        chk("abort_ack", 32'(ack), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_count_after", 32'(abn_count), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/blood_check_scheduler.md
Name: blood_check_scheduler

Overview:
- Time-shares one combinational BloodAbnormalityDetector among NUM_PATIENTS bedside sample channels.
- Arbitrates patient requests round-robin and drives the selected pH/type onto the shared detector.
- Captures the verdict and returns a per-patient ack, a result strobe, sticky alarms and a global abnormal-event counter.
- Sits between the patient sensor front-ends and the detector in the health-care monitoring datapath.

Parameters:
- NUM_PATIENTS, 4, number of requesting channels (2..8).
- CNT_W, 8, width of the saturating abnormal-event counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NUM_PATIENTS  per-patient check request; held high until matching ack.
- ph_in  input  4*NUM_PATIENTS  packed pH samples; patient i at bits [4i+3:4i].
- type_in  input  3*NUM_PATIENTS  packed blood types; patient i at bits [3i+2:3i].
- ack  output  NUM_PATIENTS  one-cycle completion pulse per patient.
- det_ph  output  4  to detector bloodPH.
- det_type  output  3  to detector bloodType.
- det_abnormal  input  1  from detector bloodAbnormality.
- result_valid  output  1  one-cycle strobe, concurrent with ack.
- result_id  output  $clog2(NUM_PATIENTS)  patient index of the current result.
- result_abn  output  1  verdict of the current result.
- alarm  output  NUM_PATIENTS  sticky abnormal alarm per patient.
- alarm_clr  input  NUM_PATIENTS  per-patient alarm clear, level-sampled.
- abn_count  output  CNT_W  total abnormal verdicts, saturating.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset value of every register output is 0: ack, det_ph, det_type, result_valid, result_id, result_abn, alarm, abn_count, busy. FSM resets to IDLE. Round-robin pointer resets so patient 0 has top priority.
- FSM state IDLE:
  - If any req bit is set, grant the first requester at or after last_grant+1, wrapping modulo NUM_PATIENTS.
  - Register that patient's ph/type into det_ph/det_type and latch the grant index, then go to DRIVE.
  - Otherwise stay in IDLE; det_ph/det_type hold their last values.
- FSM state DRIVE: one settle cycle for the detector, with det_* held stable. Go to CAPTURE.
- FSM state CAPTURE:
  - Sample det_abnormal into result_abn and assert result_valid, result_id=grant and ack[grant] for exactly one cycle.
  - Update last_grant, then return to IDLE.
- Latency: req seen high in IDLE at edge t gives ack at edge t+2. Maximum throughput is 1 check per 3 cycles.
- A requester is served again only after it drops req or after the round-robin pointer passes it. Back-to-back requests from all patients are served 0,1,2,3,0,...
- Once granted, sample data is latched. Dropping req or changing ph_in during DRIVE/CAPTURE does not affect the transaction, and the ack is still issued.
- alarm[i] sets on a CAPTURE with result_abn=1 and result_id=i. It clears when alarm_clr[i]=1. Set and clear in the same cycle: set wins.
- abn_count increments by 1 on each abnormal CAPTURE and saturates at 2^CNT_W-1 without wrapping. It is cleared only by reset.
- Asynchronous reset during DRIVE or CAPTURE aborts the check: no ack, no count update, FSM to IDLE.
- busy = (state != IDLE).

Optional Feature:
- Macro: ALARM_DEBOUNCE_EN.
- Defined: each patient has a 1-bit streak register. alarm[i] sets only on the second consecutive abnormal result for patient i; a normal result for i clears its streak. abn_count still counts every abnormal verdict. Streak bits reset to 0 and are unaffected by alarm_clr.
- Undefined: no streak registers; alarm sets on the first abnormal result.

Decomposition:
- Shared package health_pkg holds:
  - PH_W=4 and TYPE_W=3, also used by BloodAbnormalityDetector.
  - FSM state typedef {IDLE, DRIVE, CAPTURE}.
  - Saturating-increment helper function.
- Sub-module rr_arbiter (parameter N): inputs req, last_grant, any; outputs grant_idx and grant_valid. It is combinational and reusable by other sensor schedulers.

Test Plan:
- Reset/idle: rst_n low then high with req=0 -> all outputs 0, busy=0 for 20 cycles.
- Single check: req[1]=1, ph_in[7:4]=4'b0111, type_in[5:3]=3'b001, stub det_abnormal=0 -> det_ph=7, det_type=1 on the next edge; ack[1], result_valid=1, result_id=1, result_abn=0 two cycles after the grant edge; alarm=0.
- Round-robin fairness: req=4'b1111 held, stub abnormal=1 -> result_id sequence 0,1,2,3,0 at 3-cycle spacing; abn_count=5; alarm=4'b1111.
- Alarm clear race: alarm[2]=1, drive alarm_clr[2]=1 in the same cycle as an abnormal CAPTURE for patient 2 -> alarm[2] stays 1. Clear in the following idle cycle -> alarm[2]=0.
- Saturation and reset mid-op: CNT_W=2, 5 abnormal checks -> abn_count=3. Assert rst_n low during DRIVE -> no ack, FSM in IDLE, abn_count=0.
- ALARM_DEBOUNCE_EN: patient 0 verdicts abnormal, normal, abnormal, abnormal -> alarm[0] rises only after the fourth result.
